// File: rtl/approx_adder_error_monitor.sv
// Error monitor for an approximate IN_W+IN_W-bit adder: recomputes the exact sum,
// reports per-sample absolute error two cycles later and keeps saturating statistics.
module approx_adder_error_monitor #(
   parameter int IN_W  = 2,
   parameter int OUT_W = 3,
   parameter int ET    = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_a,
   input  logic [IN_W-1:0]  in_b,
   input  logic [OUT_W-1:0] approx_sum,
   output logic             err_valid,
   output logic [OUT_W-1:0] err_abs,
   output logic             err_viol,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] viol_cnt,
   output logic [OUT_W-1:0] max_err,
   output logic [CNT_W-1:0] err_sum,
   output logic             sticky_viol,
   output logic             sweep_done
);

   generate
      if (OUT_W < IN_W + 1) begin : g_width_check
         $error("approx_adder_error_monitor: OUT_W must be >= IN_W+1");
      end
   endgenerate

   // One spare bit above the wider of counter/error lets the saturating add see overflow.
   localparam int              ACC_W   = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [31:0]     ET_U    = 32'(ET);

   // stage 1
   logic [OUT_W-1:0] exact_q, exact_d;
   logic [OUT_W-1:0] approx_q, approx_d;
   logic             v1_q, v1_d;

   // stage 2
   logic [OUT_W-1:0] err_abs_q, err_abs_d;
   logic             err_viol_q, err_viol_d;
   logic             err_valid_q, err_valid_d;

   // statistics
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
   logic [CNT_W-1:0] err_sum_q, err_sum_d;
   logic [OUT_W-1:0] max_err_q, max_err_d;
   logic             sticky_q, sticky_d;

   logic [OUT_W-1:0] err_cur;
   logic             viol_cur;
   logic [ACC_W-1:0] sum_wide;

   always_comb begin
      exact_d  = OUT_W'(in_a) + OUT_W'(in_b);
      approx_d = approx_sum;
      v1_d     = in_valid & ~clear;
   end

   always_comb begin
      err_cur  = (approx_q >= exact_q) ? (approx_q - exact_q) : (exact_q - approx_q);
      viol_cur = (32'(err_cur) > ET_U);
   end

   // err_abs/err_viol hold the last retired sample between pulses.
   always_comb begin
      err_valid_d = v1_q;
      err_abs_d   = err_abs_q;
      err_viol_d  = err_viol_q;
      if (v1_q) begin
         err_abs_d  = err_cur;
         err_viol_d = viol_cur;
      end
      if (clear) begin
         err_valid_d = 1'b0;
         err_abs_d   = '0;
         err_viol_d  = 1'b0;
      end
   end

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      viol_cnt_d   = viol_cnt_q;
      err_sum_d    = err_sum_q;
      max_err_d    = max_err_q;
      sticky_d     = sticky_q;
      sum_wide     = ACC_W'(err_sum_q) + ACC_W'(err_cur);
      if (clear) begin
         sample_cnt_d = '0;
         viol_cnt_d   = '0;
         err_sum_d    = '0;
         max_err_d    = '0;
         sticky_d     = 1'b0;
      end else if (v1_q) begin
         if (sample_cnt_q != CNT_MAX) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
         end
         if (viol_cur && (viol_cnt_q != CNT_MAX)) begin
            viol_cnt_d = viol_cnt_q + 1'b1;
         end
         if (sum_wide > ACC_W'(CNT_MAX)) begin
            err_sum_d = CNT_MAX;
         end else begin
            err_sum_d = sum_wide[CNT_W-1:0];
         end
         if (err_cur > max_err_q) begin
            max_err_d = err_cur;
         end
         sticky_d = sticky_q | viol_cur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exact_q      <= '0;
         approx_q     <= '0;
         v1_q         <= 1'b0;
         err_abs_q    <= '0;
         err_viol_q   <= 1'b0;
         err_valid_q  <= 1'b0;
         sample_cnt_q <= '0;
         viol_cnt_q   <= '0;
         err_sum_q    <= '0;
         max_err_q    <= '0;
         sticky_q     <= 1'b0;
      end else begin
         exact_q      <= exact_d;
         approx_q     <= approx_d;
         v1_q         <= v1_d;
         err_abs_q    <= err_abs_d;
         err_viol_q   <= err_viol_d;
         err_valid_q  <= err_valid_d;
         sample_cnt_q <= sample_cnt_d;
         viol_cnt_q   <= viol_cnt_d;
         err_sum_q    <= err_sum_d;
         max_err_q    <= max_err_d;
         sticky_q     <= sticky_d;
      end
   end

   // When the counter cannot represent a full sweep, saturation stands in for it.
   generate
      if (CNT_W >= 2 * IN_W + 1) begin : g_sweep_cmp
         localparam logic [CNT_W-1:0] SWEEP_N = {{(CNT_W-1){1'b0}}, 1'b1} << (2 * IN_W);
         assign sweep_done = (sample_cnt_q >= SWEEP_N);
      end else begin : g_sweep_sat
         assign sweep_done = &sample_cnt_q;
      end
   endgenerate

   assign err_valid   = err_valid_q;
   assign err_abs     = err_abs_q;
   assign err_viol    = err_viol_q;
   assign sample_cnt  = sample_cnt_q;
   assign viol_cnt    = viol_cnt_q;
   assign max_err     = max_err_q;
   assign err_sum     = err_sum_q;
   assign sticky_viol = sticky_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Bench for approx_adder_error_monitor: two instances (CNT_W=16 and CNT_W=4) share
// stimulus; a queue-based model of accepted samples predicts every output.
module tb_approx_adder_error_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic [1:0] in_a, in_b;
   logic [2:0] approx_sum;

   logic        ev0, ev1, viol0, viol1, sticky0, sticky1, sweep0, sweep1;
   logic [2:0]  abs0, abs1, max0, max1;
   logic [15:0] scnt0, vcnt0, sum0;
   logic [3:0]  scnt1, vcnt1, sum1;

   approx_adder_error_monitor #(.IN_W(2), .OUT_W(3), .ET(0), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_a(in_a), .in_b(in_b), .approx_sum(approx_sum),
      .err_valid(ev0), .err_abs(abs0), .err_viol(viol0),
      .sample_cnt(scnt0), .viol_cnt(vcnt0), .max_err(max0), .err_sum(sum0),
      .sticky_viol(sticky0), .sweep_done(sweep0));

   approx_adder_error_monitor #(.IN_W(2), .OUT_W(3), .ET(0), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .in_a(in_a), .in_b(in_b), .approx_sum(approx_sum),
      .err_valid(ev1), .err_abs(abs1), .err_viol(viol1),
      .sample_cnt(scnt1), .viol_cnt(vcnt1), .max_err(max1), .err_sum(sum1),
      .sticky_viol(sticky1), .sweep_done(sweep1));

   always #5 clk = ~clk;

   typedef struct {int tag; int a; int b; int ap;} samp_t;
   samp_t pend[$];

   int n_vec = 0;
   int n_bad = 0;
   int edge_n = 0;
   int raw_n, raw_v, raw_s, m_max, exp_abs;
   bit m_sticky, exp_valid, exp_viol, chk_abs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int sat(input int raw, input int mx);
      return (raw > mx) ? mx : raw;
   endfunction

   task automatic model_zero();
      pend.delete();
      raw_n = 0; raw_v = 0; raw_s = 0; m_max = 0; m_sticky = 0;
      exp_valid = 0; exp_abs = 0; exp_viol = 0; chk_abs = 1;
   endtask

   task automatic check_all();
      chk("err_valid0", 32'(ev0), 32'(exp_valid));
      chk("err_valid1", 32'(ev1), 32'(exp_valid));
      if (exp_valid || chk_abs) begin
         chk("err_abs0", 32'(abs0), exp_abs);
         chk("err_abs1", 32'(abs1), exp_abs);
         chk("err_viol0", 32'(viol0), 32'(exp_viol));
         chk("err_viol1", 32'(viol1), 32'(exp_viol));
      end
      chk("sample_cnt0", 32'(scnt0), sat(raw_n, 65535));
      chk("viol_cnt0", 32'(vcnt0), sat(raw_v, 65535));
      chk("err_sum0", 32'(sum0), sat(raw_s, 65535));
      chk("max_err0", 32'(max0), m_max);
      chk("sticky0", 32'(sticky0), 32'(m_sticky));
      chk("sweep0", 32'(sweep0), 32'(raw_n >= 16));
      chk("sample_cnt1", 32'(scnt1), sat(raw_n, 15));
      chk("viol_cnt1", 32'(vcnt1), sat(raw_v, 15));
      chk("err_sum1", 32'(sum1), sat(raw_s, 15));
      chk("max_err1", 32'(max1), m_max);
      chk("sticky1", 32'(sticky1), 32'(m_sticky));
      chk("sweep1", 32'(sweep1), 32'(raw_n >= 15));
      chk_abs = 0;
   endtask

   // Present one cycle of inputs, advance one edge, update the model, then compare.
   task automatic step(input bit v, input int a, input int b, input int ap, input bit clr);
      samp_t s;
      int e;
      in_valid   = v;
      in_a       = 2'(a);
      in_b       = 2'(b);
      approx_sum = 3'(ap);
      clear      = clr;
      @(posedge clk);
      edge_n++;
      if (clr) begin
         model_zero();
      end else begin
         exp_valid = 0;
         if (pend.size() > 0 && pend[0].tag + 1 == edge_n) begin
            s = pend.pop_front();
            e = s.ap - (s.a + s.b);
            if (e < 0) e = -e;
            exp_valid = 1;
            exp_abs   = e;
            exp_viol  = (e > 0);
            raw_n++;
            if (exp_viol) raw_v++;
            raw_s += e;
            if (e > m_max) m_max = e;
            m_sticky = m_sticky | exp_viol;
         end
         if (v) pend.push_back('{edge_n, a, b, ap});
      end
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b1; clear = 0; in_valid = 0; in_a = 0; in_b = 0; approx_sum = 0;
      #1 rst_n = 1'b0;
      model_zero();
      #3 check_all();
      @(negedge clk) rst_n = 1'b1;

      // exact sample, then two erroneous samples
      step(1, 3, 3, 6, 0);
      step(1, 1, 2, 0, 0);
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // exhaustive sweep with an exact adder after a clear
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) step(1, i / 4, i % 4, (i / 4) + (i % 4), 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // saturation: 20 samples each with error 7
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 7, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // clear with samples in flight and a new sample in the same cycle
      step(1, 2, 2, 1, 0);
      step(1, 3, 1, 0, 0);
      step(1, 1, 1, 7, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // asynchronous reset mid-cycle with a sample in flight
      step(1, 2, 1, 0, 0);
      step(1, 1, 1, 5, 0);
      #2 rst_n = 1'b0;
      model_zero();
      #1 check_all();
      in_valid = 0;
      @(negedge clk) rst_n = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 3, 2, 2, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // randomized traffic with occasional clears
      for (int i = 0; i < 250; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 7), $urandom_range(0, 31) == 0);
      end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Downstream checker for the generated approximate 2+2-bit adder netlists: 2+2-bit operands in, 3-bit sum out, error threshold ET.
- Takes each operand pair with the sum the approximate adder produced, and recomputes the exact sum.
- Reports a per-sample absolute error through a 2-stage pipeline and keeps running statistics: sample count, violation count, max error, error sum.
- Sits between the combinational approximate adder under test and the bench/FPGA readout. Validates that the synthesized approximation honours its ET.

Parameters:
- IN_W, 2, width of each operand (a = {in1,in0}, b = {in3,in2}).
- OUT_W, 3, width of approximate sum; must be >= IN_W+1 (elaboration error otherwise).
- ET, 0, error threshold; a sample violates when abs error > ET.
- CNT_W, 16, width of sample/violation counters and error accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous statistics clear and pipeline flush.
- in_valid  in  1  sample present this cycle.
- in_a  in  IN_W  operand a.
- in_b  in  IN_W  operand b.
- approx_sum  in  OUT_W  approximate adder result; bit 0 = out0 (LSB).
- err_valid  out  1  err_abs/err_viol valid this cycle.
- err_abs  out  OUT_W  |approx_sum - (in_a+in_b)|.
- err_viol  out  1  err_abs > ET.
- sample_cnt  out  CNT_W  samples retired since reset/clear, saturating.
- viol_cnt  out  CNT_W  violating samples, saturating.
- max_err  out  OUT_W  largest err_abs retired.
- err_sum  out  CNT_W  sum of err_abs, saturating.
- sticky_viol  out  1  set on first violation, held until clear/reset.
- sweep_done  out  1  high while sample_cnt >= 2^(2*IN_W) (exhaustive sweep complete).

Behaviour:
- Reset (rst_n low, async): all pipeline valids 0, all outputs 0. This includes err_abs, err_viol, the counters, max_err, sticky_viol and sweep_done. Reset mid-operation discards in-flight samples.
- No backpressure; a sample is accepted every cycle in_valid=1.
- Stage 1, edge after acceptance (T+1):
  - Register exact = in_a + in_b, zero-extended to OUT_W (no overflow since OUT_W >= IN_W+1).
  - Register approx_sum and v1 = in_valid.
- Stage 2, edge T+2:
  - Register err_abs = (approx >= exact) ? approx - exact : exact - approx, as unsigned OUT_W.
  - Register err_viol = err_abs > ET, and err_valid = v1.
- Statistics update on the same T+2 edge when v1=1, visible with err_valid:
  - sample_cnt += 1.
  - viol_cnt += 1 if violation.
  - err_sum += err_abs.
  - max_err = max(max_err, err_abs).
  - sticky_viol |= violation.
- Saturation: sample_cnt, viol_cnt and err_sum clamp at 2^CNT_W-1 and never wrap. err_sum that would overflow is clamped to all-ones.
- sweep_done: combinational compare on sample_cnt. With CNT_W < 2*IN_W+1 it is driven by saturation (all-ones).
- clear=1 at an edge:
  - Zero all stats, both stage valids, err_valid, err_abs and err_viol.
  - A sample with in_valid in the same cycle is dropped, and in-flight samples are dropped.
  - clear has priority over any update.
- Simultaneous violation and saturation: viol_cnt holds at max and sticky_viol still sets.
- err_valid is a single-cycle pulse per sample. With back-to-back in_valid it stays high continuously, 2 cycles delayed.

Test Plan:
1. Reset, then a=3, b=3, approx_sum=6 -> at T+2 err_valid=1, err_abs=0, err_viol=0, sample_cnt=1, max_err=0, sticky_viol=0.
2. a=1, b=2, approx_sum=0, ET=0 -> err_abs=3, err_viol=1, viol_cnt=1, max_err=3, err_sum=3, sticky_viol=1. Then a=0, b=0, approx=1 -> err_abs=1, max_err stays 3, err_sum=4.
3. Exhaustive 16 pairs, back-to-back, exact adder model driving approx_sum -> 16 consecutive err_valid pulses, all err_abs=0, sample_cnt=16, sweep_done=1 from the cycle the 16th retires, viol_cnt=0.
4. CNT_W=4, 20 samples with error 7 each -> sample_cnt, viol_cnt and err_sum all hold at 15 (no wrap), max_err=7.
5. Two samples in flight, clear asserted at T+1 together with a new in_valid -> no err_valid pulses follow, all stats 0 on the next cycle.
6. rst_n dropped asynchronously mid-cycle with samples in flight -> outputs 0 immediately, no err_valid after release until new in_valid plus 2 cycles.
